vend_order_sequencer: RTL and testbench

//   Initiator side of the vending-core command interface. Accepts one customer/operator

---
 rtl/vend_order_sequencer.sv | 172 +++++++++++++++++
 tb/tb_vend_order_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_order_sequencer.sv
// Initiator for the vending core: takes one order per handshake, drives the core inputs,
// waits a fixed settle time, then returns the core's error/redLight as a response.
module vend_order_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_type,
    input  logic [3:0]       req_amount,
    input  logic [6:0]       req_money,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [6:0]       rsp_error,
    output logic             rsp_red,
    output logic             rsp_local_err,
    output logic [1:0]       mode,
    output logic [6:0]       customer_money,
    output logic [2:0]       supply_type,
    output logic [3:0]       customer_amount,
    output logic [3:0]       amount_sypply_to_add,
    input  logic [6:0]       error,
    input  logic             redLight,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    // Handshakes: a request transfers on an edge where req_valid && req_ready; a response
    // transfers on an edge where rsp_valid && rsp_ready. rsp_valid only falls after transfer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       handshake;
    logic       core_op;
    logic       rsp_is_err;

    assign core_op    = (req_op == 2'd1) || (req_op == 2'd2);
    assign rsp_is_err = (rsp_error != 7'd0) || rsp_red || rsp_local_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = core_op ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (capture) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                accept    = req_valid && rst_n;
            end
            SETTLE:  capture   = (cnt == 4'd1);
            RESP:    handshake = rsp_ready;
            default: req_ready = 1'b0;
        endcase
    end

    // Registered core drive, response and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt                  <= 4'd0;
            rsp_valid            <= 1'b0;
            rsp_error            <= 7'd0;
            rsp_red              <= 1'b0;
            rsp_local_err        <= 1'b0;
            mode                 <= 2'd0;
            customer_money       <= 7'd0;
            supply_type          <= 3'd0;
            customer_amount      <= 4'd0;
            amount_sypply_to_add <= 4'd0;
            txn_count            <= '0;
            err_count            <= '0;
        end else begin
            if (accept) begin
                cnt <= SETTLE_INIT;
                case (req_op)
                    2'd1: begin
                        mode                 <= 2'd1;
                        customer_money       <= req_money;
                        supply_type          <= req_type;
                        customer_amount      <= req_amount;
                        amount_sypply_to_add <= 4'd0;
                    end
                    2'd2: begin
                        mode                 <= 2'd2;
                        customer_money       <= 7'd0;
                        supply_type          <= req_type;
                        customer_amount      <= 4'd0;
                        amount_sypply_to_add <= req_amount;
                    end
                    default: begin
                        // Local reject: the core is never driven for these opcodes.
                        rsp_local_err <= 1'b1;
                        rsp_error     <= 7'd0;
                        rsp_red       <= 1'b0;
                        rsp_valid     <= 1'b1;
                    end
                endcase
            end

            if (state == SETTLE) begin
                if (capture) begin
                    rsp_error     <= error;
                    rsp_red       <= redLight;
                    rsp_local_err <= 1'b0;
                    rsp_valid     <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end

            if (handshake) begin
                rsp_valid            <= 1'b0;
                mode                 <= 2'd0;
                customer_money       <= 7'd0;
                supply_type          <= 3'd0;
                customer_amount      <= 4'd0;
                amount_sypply_to_add <= 4'd0;
                if (txn_count != CNT_MAX) begin
                    txn_count <= txn_count + CNT_ONE;
                end
                if (rsp_is_err && (err_count != CNT_MAX)) begin
                    err_count <= err_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vend_order_sequencer.sv
// Bench for vend_order_sequencer: directed scenarios plus randomized orders, checked
// against an order-level model (expected response queue and saturating counters).
module tb_vend_order_sequencer;

  localparam int S     = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [2:0]       req_type;
  logic [3:0]       req_amount;
  logic [6:0]       req_money;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [6:0]       rsp_error;
  logic             rsp_red;
  logic             rsp_local_err;
  logic [1:0]       mode;
  logic [6:0]       customer_money;
  logic [2:0]       supply_type;
  logic [3:0]       customer_amount;
  logic [3:0]       amount_sypply_to_add;
  logic [6:0]       error;
  logic             redLight;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] err_count;

  logic [30+2*CNT_W:0] all_out;
  logic [19:0]         core_out;
  logic [8:0]          rsp_out;

  int         checks;
  int         failures;
  int         exp_txn;
  int         exp_err;
  logic [8:0] exp_q[$];

  vend_order_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_type(req_type),
    .req_amount(req_amount), .req_money(req_money),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error), .rsp_red(rsp_red),
    .rsp_local_err(rsp_local_err),
    .mode(mode), .customer_money(customer_money), .supply_type(supply_type),
    .customer_amount(customer_amount), .amount_sypply_to_add(amount_sypply_to_add),
    .error(error), .redLight(redLight), .txn_count(txn_count), .err_count(err_count)
  );

  assign core_out = {mode, customer_money, supply_type, customer_amount, amount_sypply_to_add};
  assign rsp_out  = {rsp_local_err, rsp_red, rsp_error};
  assign all_out  = {req_ready, rsp_valid, rsp_out, core_out, txn_count, err_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_garbage(input logic v);
    req_valid  = v;
    req_op     = 2'($urandom);
    req_type   = 3'($urandom);
    req_amount = 4'($urandom);
    req_money  = 7'($urandom);
    error      = 7'($urandom);
    redLight   = 1'($urandom);
  endtask

  // Full order lifecycle; bp = cycles of rsp_ready=0 while the response is pending.
  task automatic run_order(input logic [1:0] op, input logic [2:0] typ, input logic [3:0] amt,
                           input logic [6:0] money, input logic [6:0] cerr, input logic cred,
                           input int bp);
    logic        is_local;
    logic [19:0] e_core;
    logic [8:0]  e_rsp;
    logic        e_flag;
    is_local = (op == 2'd0) || (op == 2'd3);
    e_core   = {(is_local ? 2'd0 : op), ((op == 2'd1) ? money : 7'd0),
                (is_local ? 3'd0 : typ), ((op == 2'd1) ? amt : 4'd0),
                ((op == 2'd2) ? amt : 4'd0)};
    e_rsp    = is_local ? 9'h100 : {1'b0, cred, cerr};
    e_flag   = is_local || cred || (cerr != 7'd0);
    exp_q.push_back(e_rsp);

    @(negedge clk);
    drive_garbage(1'b1);
    req_op = op; req_type = typ; req_amount = amt; req_money = money;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready got=%b exp=1", req_ready);
    end

    @(negedge clk);
    drive_garbage(1'($urandom));
    checks++;
    if (core_out !== e_core) begin
      failures++;
      $display("FAIL core_drive got=%h exp=%h", core_out, e_core);
    end

    if (!is_local) begin
      for (int k = 1; k <= S; k++) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL early_rsp k=%0d got=%b exp=0", k, rsp_valid);
        end
        if (k == S) begin
          error = cerr; redLight = cred;
        end
        @(negedge clk);
        drive_garbage(1'($urandom));
        checks++;
        if (core_out !== e_core) begin
          failures++;
          $display("FAIL core_hold k=%0d got=%h exp=%h", k, core_out, e_core);
        end
      end
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_latency got=%b exp=1", rsp_valid);
    end

    for (int c = 0; c < bp; c++) begin
      drive_garbage(1'b1);
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_out, core_out} !== {1'b1, 1'b0, e_rsp, e_core}) begin
        failures++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c,
                 {rsp_valid, req_ready, rsp_out, core_out}, {1'b1, 1'b0, e_rsp, e_core});
      end
    end

    drive_garbage(1'b0);
    rsp_ready = 1'b1;
    e_rsp = exp_q.pop_front();
    checks++;
    if (rsp_out !== e_rsp) begin
      failures++;
      $display("FAIL rsp_data got=%h exp=%h", rsp_out, e_rsp);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_txn < CMAX) exp_txn++;
    if (e_flag && exp_err < CMAX) exp_err++;
    checks++;
    if ({rsp_valid, req_ready, core_out} !== {1'b0, 1'b1, 20'd0}) begin
      failures++;
      $display("FAIL rsp_release got=%h exp=%h", {rsp_valid, req_ready, core_out}, {2'b01, 20'd0});
    end
    checks++;
    if ({txn_count, err_count} !== {CNT_W'(exp_txn), CNT_W'(exp_err)}) begin
      failures++;
      $display("FAIL counters got=%0d/%0d exp=%0d/%0d", txn_count, err_count, exp_txn, exp_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    drive_garbage(1'b1);
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    repeat (2) @(negedge clk);
    drive_garbage(1'b0);
    rst_n = 1'b1;
    exp_txn = 0; exp_err = 0; exp_q.delete();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, core_out} !== {2'b10, 20'd0}) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", {req_ready, rsp_valid, core_out}, {2'b10, 20'd0});
    end
  endtask

  task automatic test_purchase;
    run_order(2'd1, 3'd3, 4'd2, 7'd40, 7'd0, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_garbage(1'b1);
    req_op = 2'd1; req_money = 7'd9;
    @(negedge clk);
    drive_garbage(1'b0);
    repeat (S) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=0", all_out);
    end
    exp_txn = 0; exp_err = 0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_release got=%b exp=10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_restock;
    run_order(2'd2, 3'd5, 4'd9, 7'd77, 7'h04, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    run_order(2'd1, 3'd1, 4'd4, 7'd100, 7'h21, 1'b0, 5);
  endtask

  task automatic test_local_reject;
    run_order(2'd3, 3'd6, 4'd7, 7'd12, 7'h7f, 1'b1, 2);
    run_order(2'd0, 3'd2, 4'd1, 7'd3, 7'h00, 1'b0, 0);
  endtask

  task automatic test_reset_in_settle;
    @(negedge clk);
    drive_garbage(1'b1);
    req_op = 2'd2;
    @(negedge clk);
    drive_garbage(1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_settle_outputs got=%h exp=0", all_out);
    end
    exp_txn = 0; exp_err = 0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < S + 4; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, txn_count} !== {2'b01, CNT_W'(0)}) begin
        failures++;
        $display("FAIL reset_settle_no_rsp c=%0d got=%h exp=%h", c,
                 {rsp_valid, req_ready, txn_count}, {2'b01, CNT_W'(0)});
      end
    end
    run_order(2'd1, 3'd7, 4'd15, 7'd127, 7'h00, 1'b0, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      run_order(2'($urandom), 3'($urandom), 4'($urandom), 7'($urandom),
                (($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom)), 1'($urandom),
                $urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation;
    for (int n = 0; n < CMAX + 3; n++) begin
      run_order(2'd3, 3'($urandom), 4'($urandom), 7'($urandom), 7'd0, 1'b0, 0);
    end
    checks++;
    if ({txn_count, err_count} !== {CNT_W'(CMAX), CNT_W'(CMAX)}) begin
      failures++;
      $display("FAIL saturation got=%0d/%0d exp=%0d/%0d", txn_count, err_count, CMAX, CMAX);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_txn = 0; exp_err = 0;
    test_reset();
    test_purchase();
    test_reset_mid();
    test_restock();
    test_backpressure();
    test_local_reject();
    test_reset_in_settle();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
